pipeline_stall_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RISC-V core. It combines the load-use hazard flag from the hazard detector, branch/jump resolution from EX, and the data-memory ready handshake from MEM. From these it drives every pipeline-register write-enable and flush, plus PC write-enable. It also times out stuck memory accesses and keeps saturating event counters for debug.

---
 rtl/pipeline_stall_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer: stall, flush and PC enables,
// memory-timeout detection and saturating debug counters.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_n,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_timer;
  logic [7:0]       w_timer_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_pass;
  logic             w_inc_stall;
  logic             w_inc_flush;
  logic             w_inc_wait;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  // State, timer and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_timer <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, enables, flushes and counter increments
  always_comb begin
    w_next      = r_state;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    w_pass      = 1'b0;
    w_inc_stall = 1'b0;
    w_inc_flush = 1'b0;
    w_inc_wait  = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    unique case (r_state)
      BOOT: begin
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        w_next     = RUN;
      end
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          w_timer_nxt = 8'd1;
          w_next      = MEM_WAIT;
          w_inc_wait  = 1'b1;
        end else begin
          w_pass = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_pass      = 1'b1;
          w_next      = RUN;
          w_timer_nxt = 8'd0;
        end else begin
          w_inc_wait = 1'b1;
          if (r_timer + 8'd1 == TO_LIM) begin
            w_next    = ERROR;
            w_err_nxt = 1'b1;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
      end
      ERROR: begin
        w_err_nxt = 1'b1;
      end
    endcase
    // Branch squash outranks load-use: the hazarding op dies anyway
    if (w_pass) begin
      if (ex_branch_taken) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        w_inc_flush = 1'b1;
      end else if (!hazard_n) begin
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        idex_flush  = 1'b1;
        w_inc_stall = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
        memwb_we = 1'b1;
      end
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_inc_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_inc_flush && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_inc_wait && r_wait_cnt != '1)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign mem_err   = r_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign wait_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl.
// Small TIMEOUT and counter width exercise timeout and saturation.
module tb_pipeline_stall_ctrl;

  localparam int TO = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hazard_n;
  logic          ex_branch_taken;
  logic          dmem_req;
  logic          dmem_ready;
  logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic          ifid_flush, idex_flush, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  logic [6:0] en;
  logic [5:0] lu;
  assign en = {pc_we, ifid_we, idex_we, exmem_we,
               memwb_we, ifid_flush, idex_flush};
  assign lu = {pc_we, ifid_we, exmem_we,
               memwb_we, ifid_flush, idex_flush};

  localparam logic [6:0] E_BOOT = 7'b0111111;
  localparam logic [6:0] E_RUN  = 7'b1111100;
  localparam logic [6:0] E_BR   = 7'b1111111;
  localparam logic [6:0] E_FRZ  = 7'b0000000;
  localparam logic [5:0] E_LU   = 6'b001101;

  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_n(hazard_n),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic b,
                       input logic rq, input logic rd);
    @(negedge clk);
    hazard_n        = h;
    ex_branch_taken = b;
    dmem_req        = rq;
    dmem_ready      = rd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hazard_n = 1'b1;
    ex_branch_taken = 1'b0;
    dmem_req = 1'b0;
    dmem_ready = 1'b0;

    @(negedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);

    rst_n = 1'b1; #1;
    chk("boot_state", 32'(state), 32'd0);
    chk("boot_en", 32'(en), 32'(E_BOOT));

    drive(1, 0, 0, 0);
    chk("run_state", 32'(state), 32'd1);
    chk("run_en", 32'(en), 32'(E_RUN));
    chk("run_cnts", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);

    drive(0, 0, 0, 0);
    chk("lu_en", 32'(lu), 32'(E_LU));
    drive(1, 0, 0, 0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_after_en", 32'(en), 32'(E_RUN));

    drive(0, 1, 0, 0);
    chk("br_en", 32'(en), 32'(E_BR));
    drive(1, 0, 0, 0);
    chk("br_fcnt", 32'(flush_cnt), 32'd1);
    chk("br_scnt", 32'(stall_cnt), 32'd1);

    drive(1, 0, 1, 0);
    chk("miss1_en", 32'(en), 32'(E_FRZ));
    chk("miss1_st", 32'(state), 32'd1);
    drive(1, 0, 1, 0);
    chk("miss2_en", 32'(en), 32'(E_FRZ));
    chk("miss2_st", 32'(state), 32'd2);
    drive(1, 0, 1, 0);
    chk("miss3_en", 32'(en), 32'(E_FRZ));
    drive(1, 1, 1, 1);
    chk("rel_en", 32'(en), 32'(E_BR));
    drive(1, 0, 0, 0);
    chk("rel_st", 32'(state), 32'd1);
    chk("rel_wcnt", 32'(wait_cnt), 32'd3);
    chk("rel_fcnt", 32'(flush_cnt), 32'd2);
    chk("rel_err", 32'(mem_err), 32'd0);

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      chk("sat_lu_en", 32'(lu), 32'(E_LU));
    end
    drive(1, 0, 0, 0);
    chk("sat_scnt", 32'(stall_cnt), 32'd3);

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0);
      chk("to_en", 32'(en), 32'(E_FRZ));
    end
    chk("to_pre_err", 32'(mem_err), 32'd0);
    drive(1, 0, 1, 0);
    chk("to_last_st", 32'(state), 32'd2);
    chk("to_last_en", 32'(en), 32'(E_FRZ));
    drive(0, 1, 1, 1);
    chk("err_st", 32'(state), 32'd3);
    chk("err_flag", 32'(mem_err), 32'd1);
    chk("err_en", 32'(en), 32'(E_FRZ));
    chk("err_wcnt", 32'(wait_cnt), 32'd3);
    drive(0, 1, 0, 1);
    chk("err_hold_st", 32'(state), 32'd3);
    chk("err_hold_flag", 32'(mem_err), 32'd1);
    chk("err_hold_en", 32'(en), 32'(E_FRZ));
    chk("err_hold_fcnt", 32'(flush_cnt), 32'd2);

    #1 rst_n = 1'b0;
    #1;
    chk("arst_err", 32'(mem_err), 32'd0);
    chk("arst_st", 32'(state), 32'd0);
    chk("arst_cnts", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
